interleave_ctrl: RTL and testbench
==================================

INTERLEAVE_CTRL -- requirements
Module: interleave_ctrl

Interface
REQ-001 Parameter n, default 7: Hamming codeword length in bits.
REQ-002 Parameter symbol_num, default 4: codewords per interleave frame; frame length F = n*symbol_num.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cw_i  input  n  codeword from encoder.
REQ-006 cw_valid  input  1  cw_i valid.
REQ-007 cw_ready  output  1  controller accepts cw_i this cycle.
REQ-008 flush  input  1  close a partially filled frame.
REQ-009 il_en  output  1  enable to the interleaver datapath.
REQ-010 il_data  output  F  frame to the interleaver; codeword k (k-th accepted in the frame) at bits [k*n +: n].
REQ-011 il_data_o  input  F  interleaver result, valid one cycle after il_en.
REQ-012 bit_o  output  1  serial interleaved bit.
REQ-013 bit_valid  output  1  bit_o valid.
REQ-014 bit_ready  input  1  downstream accepts bit_o.
REQ-015 frame_start  output  1  high with the first bit of a frame (qualified by bit_valid).
REQ-016 frame_end  output  1  high with the last bit of a frame (qualified by bit_valid).

Function
REQ-017 FSM states FILL, LAUNCH, CAPTURE, SEND; reset state FILL.
REQ-018 FILL: cw_ready=1; on cw_valid, store cw_i at slot cw_cnt and increment cw_cnt; on accepting slot symbol_num-1, go to LAUNCH.
REQ-019 FILL with flush=1 and cw_cnt>0: zero all unfilled slots and go to LAUNCH; a codeword accepted in the same cycle is stored before padding.
REQ-020 FILL with flush=1 and cw_cnt=0 and no accepted codeword: ignored, stay in FILL.
REQ-021 LAUNCH: il_en=1 for exactly one cycle, il_data = frame buffer, cw_ready=0; next state CAPTURE.
REQ-022 CAPTURE: load il_data_o into output shift register, bit_cnt=0; next state SEND; il_en=0.
REQ-023 il_en SHALL be 0 in every state other than LAUNCH; il_data holds the frame buffer at all times.
REQ-024 SEND: bit_valid=1, bit_o = shift register bit bit_cnt (bit 0 first); transfer occurs when bit_valid and bit_ready.
REQ-025 On transfer, bit_cnt increments; on transfer of bit F-1, clear cw_cnt and go to FILL.
REQ-026 bit_ready=0 in SEND: bit_o, bit_cnt, frame_start, frame_end held stable.
REQ-027 frame_start = bit_valid and bit_cnt=0; frame_end = bit_valid and bit_cnt=F-1.
REQ-028 cw_ready=0 in LAUNCH, CAPTURE, SEND (no overlap of fill and send).
REQ-029 Latency: last codeword accepted at cycle T -> il_en at T+1 -> first bit_valid at T+3.
REQ-030 Steady-state throughput with bit_ready=1: one bit per cycle; frame period = symbol_num + F + 2 cycles with cw_valid held high.
REQ-031 cw_cnt width ceil(log2(symbol_num+1)), bit_cnt width ceil(log2(F+1)); no wrap beyond the limits above.

Reset
REQ-032 rst=1 at a clock edge: state=FILL, cw_cnt=0, bit_cnt=0, frame buffer and shift register=0.
REQ-033 Outputs during and after reset: cw_ready=1 (FILL), il_en=0, il_data=0, bit_o=0, bit_valid=0, frame_start=0, frame_end=0.
REQ-034 Reset in any state, including mid-SEND, discards the frame; no partial frame is resumed.

Verification
REQ-035 Codewords 0x7F,0,0,0 with n=7, symbol_num=4, bit_ready=1 -> one il_en pulse, il_data=0x000007F; serial bits 0,4,8,...,24 = 1, all others 0; frame_start on bit 0, frame_end on bit 27.
REQ-036 Codewords 0x01,0x02,0x04,0x08 back to back -> first bit_valid exactly 3 cycles after the 4th accept; 28 bits out, matching the interleaver permutation.
REQ-037 bit_ready toggled 1-0-0-1 pseudo-randomly during SEND -> bit sequence identical to REQ-036, bit_o stable while bit_ready=0, no bit lost or duplicated.
REQ-038 Two codewords 0x7F,0x7F then flush=1 -> il_data=0x0003FFF (slots 2-3 zero); flush with cw_cnt=0 -> no il_en.
REQ-039 rst asserted on bit 10 of SEND -> next cycle bit_valid=0, cw_ready=1; new frame processed normally.
REQ-040 cw_valid held high across two frames -> cw_ready=0 from LAUNCH through last bit; second frame starts only after frame_end transfer.

Source files
------------

// File: rtl/interleave_ctrl_if.sv
// Handshake and datapath bundle between the codeword source, the interleaver
// datapath and the serial sink of interleave_ctrl.
interface interleave_ctrl_if #(
  parameter int n          = 7,
  parameter int symbol_num = 4
);
  localparam int F = n * symbol_num;

  logic [n-1:0] cw_i;
  logic         cw_valid;
  logic         cw_ready;
  logic         flush;
  logic         il_en;
  logic [F-1:0] il_data;
  logic [F-1:0] il_data_o;
  logic         bit_o;
  logic         bit_valid;
  logic         bit_ready;
  logic         frame_start;
  logic         frame_end;

  modport slave (
    input  cw_i, cw_valid, flush, il_data_o, bit_ready,
    output cw_ready, il_en, il_data, bit_o, bit_valid, frame_start, frame_end
  );

  modport master (
    output cw_i, cw_valid, flush, il_data_o, bit_ready,
    input  cw_ready, il_en, il_data, bit_o, bit_valid, frame_start, frame_end
  );
endinterface

// File: rtl/interleave_ctrl.sv
// Collects codewords into a frame, launches the interleaver once per frame and
// serialises the interleaved result bit 0 first; fill and send never overlap.
module interleave_ctrl #(
  parameter int n          = 7,
  parameter int symbol_num = 4
) (
  input  logic              clk,
  input  logic              rst,
  interleave_ctrl_if.slave  bus
);
  localparam int F     = n * symbol_num;
  localparam int CW_W  = $clog2(symbol_num + 1);
  localparam int BIT_W = $clog2(F + 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    LAUNCH  = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW_W-1:0]  r_cw_cnt;
  logic [CW_W-1:0]  w_cw_cnt_nxt;
  logic [CW_W-1:0]  w_cnt_acc;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [BIT_W-1:0] w_bit_cnt_nxt;
  logic [F-1:0]     r_frame;
  logic [F-1:0]     w_frame_nxt;
  logic [F-1:0]     r_shift;
  logic [F-1:0]     w_shift_nxt;
  logic             w_accept;
  logic             w_pad;
  logic             w_xfer;

  // next-state, frame buffer and shift register update
  always_comb begin
    w_state_nxt   = r_state;
    w_cw_cnt_nxt  = r_cw_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_frame_nxt   = r_frame;
    w_shift_nxt   = r_shift;
    w_accept      = (r_state == FILL) && bus.cw_valid;
    w_cnt_acc     = r_cw_cnt + {{(CW_W-1){1'b0}}, w_accept};
    w_pad         = bus.flush && (w_cnt_acc != {CW_W{1'b0}});
    w_xfer        = (r_state == SEND) && bus.bit_ready;
    case (r_state)
      FILL: begin
        // a codeword accepted alongside flush lands before the zero padding
        for (int k = 0; k < symbol_num; k++) begin
          if (w_accept && (r_cw_cnt == CW_W'(k))) begin
            w_frame_nxt[k*n +: n] = bus.cw_i;
          end else if (w_pad && (CW_W'(k) >= w_cnt_acc)) begin
            w_frame_nxt[k*n +: n] = {n{1'b0}};
          end else begin
            w_frame_nxt[k*n +: n] = r_frame[k*n +: n];
          end
        end
        w_cw_cnt_nxt = w_cnt_acc;
        if (w_cnt_acc == CW_W'(symbol_num)) begin
          w_state_nxt = LAUNCH;
        end else if (w_pad) begin
          w_state_nxt = LAUNCH;
        end else begin
          w_state_nxt = FILL;
        end
      end
      LAUNCH: begin
        w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_shift_nxt   = bus.il_data_o;
        w_bit_cnt_nxt = {BIT_W{1'b0}};
        w_state_nxt   = SEND;
      end
      SEND: begin
        if (w_xfer) begin
          w_shift_nxt = {1'b0, r_shift[F-1:1]};
          if (r_bit_cnt == BIT_W'(F - 1)) begin
            w_bit_cnt_nxt = {BIT_W{1'b0}};
            w_cw_cnt_nxt  = {CW_W{1'b0}};
            w_state_nxt   = FILL;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + {{(BIT_W-1){1'b0}}, 1'b1};
            w_state_nxt   = SEND;
          end
        end else begin
          w_state_nxt = SEND;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // state and datapath registers; reset discards any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_cw_cnt  <= {CW_W{1'b0}};
      r_bit_cnt <= {BIT_W{1'b0}};
      r_frame   <= {F{1'b0}};
      r_shift   <= {F{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_cw_cnt  <= w_cw_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_frame   <= w_frame_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // outputs decode registered state only
  assign bus.cw_ready    = (r_state == FILL);
  assign bus.il_en       = (r_state == LAUNCH);
  assign bus.il_data     = r_frame;
  assign bus.bit_valid   = (r_state == SEND);
  assign bus.bit_o       = (r_state == SEND) & r_shift[0];
  assign bus.frame_start = (r_state == SEND) && (r_bit_cnt == {BIT_W{1'b0}});
  assign bus.frame_end   = (r_state == SEND) && (r_bit_cnt == BIT_W'(F - 1));
endmodule

// File: tb/tb_interleave_ctrl.sv
// Scoreboard bench for interleave_ctrl with a behavioural interleaver model.
module tb_interleave_ctrl;
  localparam int N = 7;
  localparam int S = 4;
  localparam int F = N * S;

  logic clk;
  logic rst;
  interleave_ctrl_if #(.n(N), .symbol_num(S)) bus ();

  interleave_ctrl #(.n(N), .symbol_num(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           close_cyc = 0;
  int           mon_idx = 0;
  bit           rnd_rdy = 1'b0;
  bit           prev_valid = 1'b0;
  bit           hold_pend = 1'b0;
  logic         hold_bit, hold_fs, hold_fe;
  logic [F-1:0] m_frame = '0;
  int           m_cnt = 0;
  logic [F-1:0] il_q[$];
  logic         bit_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [F-1:0] ilv(input logic [F-1:0] d);
    logic [F-1:0] o;
    o = '0;
    for (int b = 0; b < N; b++)
      for (int k = 0; k < S; k++)
        o[b*S + k] = d[k*N + b];
    return o;
  endfunction

  // interleaver model: result one cycle after il_en
  always @(posedge clk) begin
    if (rst) bus.il_data_o <= '0;
    else if (bus.il_en) bus.il_data_o <= ilv(bus.il_data);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic close_frame();
    logic [F-1:0] p;
    il_q.push_back(m_frame);
    p = ilv(m_frame);
    for (int i = 0; i < F; i++) bit_q.push_back(p[i]);
    m_frame = '0;
    m_cnt = 0;
  endtask

  task automatic put_cw(input logic [N-1:0] cw, input bit with_flush);
    int budget;
    bus.cw_i = cw;
    bus.cw_valid = 1'b1;
    bus.flush = with_flush;
    budget = 0;
    @(negedge clk);
    while (!bus.cw_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!bus.cw_ready) check_val("accept_timeout", 32'd0, 32'd1);
    close_cyc = cyc;
    m_frame[m_cnt*N +: N] = cw;
    m_cnt++;
    if (m_cnt == S || with_flush) close_frame();
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic flush_only();
    bus.flush = 1'b1;
    bus.cw_valid = 1'b0;
    @(negedge clk);
    check_val("flush_in_fill", 32'(bus.cw_ready), 32'd1);
    if (m_cnt > 0) begin
      close_cyc = cyc;
      close_frame();
    end
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    @(negedge clk);
    while ((bit_q.size() != 0 || il_q.size() != 0 || !bus.cw_ready) && budget < 300) begin
      budget++;
      @(negedge clk);
    end
    check_val("drain_done", 32'(bit_q.size() == 0 && il_q.size() == 0), 32'd1);
    @(posedge clk); #1;
  endtask

  // bit_ready source
  initial begin
    bus.bit_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.bit_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.il_en) begin
        if (il_q.size() == 0) check_val("il_en_unexpected", 32'd1, 32'd0);
        else check_val("il_data", 32'(bus.il_data), 32'(il_q.pop_front()));
        check_val("il_en_latency", 32'(cyc - close_cyc), 32'd1);
      end
      if (bus.bit_valid || bus.il_en) check_val("cw_ready_busy", 32'(bus.cw_ready), 32'd0);
      if (hold_pend) begin
        check_val("hold_valid", 32'(bus.bit_valid), 32'd1);
        check_val("hold_bit", 32'(bus.bit_o), 32'(hold_bit));
        check_val("hold_fs", 32'(bus.frame_start), 32'(hold_fs));
        check_val("hold_fe", 32'(bus.frame_end), 32'(hold_fe));
      end
      if (bus.bit_valid && !prev_valid)
        check_val("first_bit_latency", 32'(cyc - close_cyc), 32'd3);
      if (bus.bit_valid && bus.bit_ready) begin
        if (bit_q.size() == 0) check_val("bit_unexpected", 32'd1, 32'd0);
        else check_val("bit_o", 32'(bus.bit_o), 32'(bit_q.pop_front()));
        check_val("frame_start", 32'(bus.frame_start), 32'(mon_idx == 0));
        check_val("frame_end", 32'(bus.frame_end), 32'(mon_idx == F - 1));
        mon_idx = (mon_idx == F - 1) ? 0 : mon_idx + 1;
      end
      hold_pend = bus.bit_valid && !bus.bit_ready;
      hold_bit = bus.bit_o;
      hold_fs = bus.frame_start;
      hold_fe = bus.frame_end;
      prev_valid = bus.bit_valid;
    end
  end

  initial begin
    int budget;
    rst = 1'b1;
    bus.cw_i = '0;
    bus.cw_valid = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cw_ready", 32'(bus.cw_ready), 32'd1);
    check_val("rst_il_en", 32'(bus.il_en), 32'd0);
    check_val("rst_il_data", 32'(bus.il_data), 32'd0);
    check_val("rst_bit_o", 32'(bus.bit_o), 32'd0);
    check_val("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    check_val("rst_fs_fe", 32'({bus.frame_start, bus.frame_end}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single full-ones codeword in slot 0
    put_cw(7'h7F, 1'b0); put_cw(7'h00, 1'b0); put_cw(7'h00, 1'b0); put_cw(7'h00, 1'b0);
    wait_drain();

    // one-hot codewords back to back
    put_cw(7'h01, 1'b0); put_cw(7'h02, 1'b0); put_cw(7'h04, 1'b0); put_cw(7'h08, 1'b0);
    wait_drain();

    // same frame with a stalling sink
    rnd_rdy = 1'b1;
    put_cw(7'h01, 1'b0); put_cw(7'h02, 1'b0); put_cw(7'h04, 1'b0); put_cw(7'h08, 1'b0);
    wait_drain();
    rnd_rdy = 1'b0;

    // partial frames closed by flush, standalone and with a codeword
    put_cw(7'h7F, 1'b0); put_cw(7'h7F, 1'b0);
    flush_only();
    wait_drain();
    put_cw(7'h55, 1'b1);
    wait_drain();

    // flush on an empty frame must not launch
    flush_only();
    repeat (10) @(posedge clk);
    #1;
    check_val("empty_flush_idle", 32'(bus.cw_ready), 32'd1);

    // reset while bit 10 is on the wire
    put_cw(7'h11, 1'b0); put_cw(7'h22, 1'b0); put_cw(7'h33, 1'b0); put_cw(7'h44, 1'b0);
    budget = 0;
    @(posedge clk); #1;
    while (!(bus.bit_valid && mon_idx == 10) && budget < 200) begin
      budget++;
      @(posedge clk); #1;
    end
    check_val("reach_bit10", 32'(mon_idx), 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_bit_valid", 32'(bus.bit_valid), 32'd0);
    check_val("midrst_cw_ready", 32'(bus.cw_ready), 32'd1);
    check_val("midrst_il_data", 32'(bus.il_data), 32'd0);
    bit_q.delete();
    il_q.delete();
    mon_idx = 0;
    m_cnt = 0;
    m_frame = '0;
    put_cw(7'h7F, 1'b0); put_cw(7'h00, 1'b0); put_cw(7'h00, 1'b0); put_cw(7'h00, 1'b0);
    wait_drain();

    // cw_valid held across two frames
    put_cw(7'h3C, 1'b0); put_cw(7'h5A, 1'b0); put_cw(7'h66, 1'b0); put_cw(7'h0F, 1'b0);
    bus.cw_valid = 1'b1;
    put_cw(7'h70, 1'b0); put_cw(7'h01, 1'b0); put_cw(7'h2B, 1'b0); put_cw(7'h54, 1'b0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
